axi4_burst_mem_slave: RTL and testbench
=======================================

# axi4_burst_mem_slave

AXI4 (full) memory-mapped slave with an internal word-addressed register-file memory; the responder side of the AXI4 master BFM bursts issued by the peripheral's BFM benches. Accepts FIXED, INCR and WRAP bursts of 1-256 beats with 32-bit data. Independent write and read engines, one outstanding transaction each. Gives the RV64 core wrapper a self-contained memory target for M0/M1 master traffic and for BFM write/read-compare tests.

## Interface
- C_S_AXI_ID_WIDTH, 1: width of AWID/BID/ARID/RID.
- C_S_AXI_ADDR_WIDTH, 32: byte address width.
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 supported.
- C_MEM_ADDR_BITS, 8: log2 of memory depth in 32-bit words (256 words).
- S_AXI_ACLK  in  1  single clock; all logic rising-edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWID/AWADDR/AWLEN[8]/AWSIZE[3]/AWBURST[2]  in  write address/control.
- S_AXI_AWLOCK/AWCACHE/AWPROT/AWQOS/AWREGION/AWUSER  in  accepted, ignored.
- S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  AW handshake.
- S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WLAST in 1, S_AXI_WUSER in 1  write data.
- S_AXI_WVALID in 1, S_AXI_WREADY out 1  W handshake.
- S_AXI_BID out ID, S_AXI_BRESP out 2, S_AXI_BUSER out 1 (tied 0), S_AXI_BVALID out 1, S_AXI_BREADY in 1.
- S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST in; ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION/ARUSER in, ignored.
- S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  AR handshake.
- S_AXI_RID out ID, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RLAST out 1, S_AXI_RUSER out 1 (tied 0), S_AXI_RVALID out 1, S_AXI_RREADY in 1.

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. AWREADY=1 only in W_IDLE; on AW handshake latch ID, addr, len, burst, size; err flag set if AWSIZE!=3'b010 or WRAP with len not in {1,3,7,15}.
- W_DATA: WREADY=1; each W handshake writes memory word addr[C_MEM_ADDR_BITS+1:2] per WSTRB byte lanes (suppressed if err); beat counter increments; WLAST must equal (beat==len), else err set. After beat len -> W_RESP regardless of WLAST.
- W_RESP: BVALID=1, BID=latched ID, BRESP=2'b10 (SLVERR) if err else 2'b00; hold until BREADY, then W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE. ARREADY=1 only in R_IDLE; same latch/err rules. R_DATA: RVALID=1, RDATA=mem[addr] (0 if err), RID latched, RRESP per err, RLAST=(beat==len). Beat advances on RVALID&RREADY; after last beat -> R_IDLE.
- Address generation per beat: FIXED keeps address; INCR adds 4; WRAP adds 4 then wraps to boundary = addr & ~((len+1)*4-1). Memory index wraps modulo depth; no 4 KB or decode error. Unaligned start: low two bits ignored for memory index.
- Burst type 2'b11 (reserved) treated as INCR with SLVERR.
- Read and write engines run concurrently; a read beat returns memory contents as of the preceding clock edge (a write in the same cycle is not forwarded).

## Timing
- Reset (ARESETN low, async): all outputs 0, FSMs idle; AWREADY/ARREADY rise on first edge after release.
- AW handshake at edge N -> WREADY=1 from N+1. Last W beat at edge M -> BVALID=1 from M+1.
- AR handshake at edge N -> RVALID=1 with first beat from N+1; with RREADY held high, one beat per cycle, RLAST on beat len, ARREADY=1 at edge after last beat.
- AWREADY/ARREADY drop the cycle after handshake; no new AW/AR accepted until B/final R completes.
- RDATA/RRESP/RLAST/RID stable while RVALID&!RREADY; BVALID/BRESP stable until BREADY.
- Reset mid-burst: transaction aborted, no response issued; memory contents unaffected by reset.

## Structure
- Package axi4_mem_pkg: burst type constants (FIXED/INCR/WRAP), RESP_OKAY/RESP_SLVERR, SIZE_4_BYTES, FSM state enums.
- Sub-module axi4_burst_addr_gen (combinational next-address from addr, len, burst), instantiated once per engine.

## Test plan
- Reset release -> AWREADY=ARREADY=1 one cycle later, all other outputs 0.
- INCR write len=15 at 0x0 of 0x00abcdef..FFFFFFFF (16 words), then WRAP read len=15 at 0x0 -> identical 512-bit data, BRESP=RRESP=OKAY, RLAST on beat 15 only.
- WRAP read len=3 at 0x28 -> words 0x28,0x2C,0x20,0x24 returned in that order.
- FIXED write len=3 to 0x40 with WSTRB 4'b0001 and data 0x11,0x22,0x33,0x44 over prior 0xFFFFFFFF -> read gives 0xFFFFFF44.
- RREADY toggled every other cycle during len=7 read -> no beat lost/duplicated, RDATA held while stalled; WLAST asserted at beat 2 of len=3 write -> BRESP=2'b10; AWSIZE=3'b011 -> SLVERR, memory unchanged.
- ARESETN pulled low mid write burst -> BVALID never asserted, AWREADY=1 after release, next write completes OKAY.

Source files
------------

// File: rtl/axi4_burst_mem_slave_pkg.sv
// Shared definitions for the AXI4 burst memory slave.
// Contents: burst-type and response codes, the only supported beat size,
// the write/read engine state encodings, the debug state bundle, and a
// helper that classifies an AW/AR request as erroneous.
package axi4_mem_pkg;

    localparam logic [1:0] BURST_FIXED  = 2'b00;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] BURST_WRAP   = 2'b10;
    localparam logic [1:0] BURST_RSVD   = 2'b11;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    localparam logic [2:0] SIZE_4_BYTES = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    // Live state of both engines, exported so checkers can bind to it.
    typedef struct packed {
        wr_state_e wr_state;
        rd_state_e rd_state;
    } dbg_t;

    // A request is answered with SLVERR when it is not a 4-byte beat, uses the
    // reserved burst type, or is a WRAP whose beat count is not 2/4/8/16.
    function automatic logic burst_err(input logic [2:0] size,
                                       input logic [1:0] burst,
                                       input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != SIZE_4_BYTES) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 bus bundle between a master and axi4_burst_mem_slave.
// Parameters: ID_W (AxID/xID width), ADDR_W (byte address width); data is 32 bits.
// Modports: slave (memory side), master (bench / initiator side).
// Every channel uses standard AXI valid/ready: a transfer happens on a rising
// clock edge where both valid and ready are high; once valid is raised its
// payload is held until that edge.
interface axi4_burst_mem_slave_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32
);
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [3:0]        awqos;
    logic [3:0]        awregion;
    logic              awuser;
    logic              awvalid;
    logic              awready;

    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wuser;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              buser;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic [3:0]        arregion;
    logic              aruser;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              ruser;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

endinterface

// File: rtl/axi4_burst_mem_slave_addr_gen.sv
// Combinational next-beat address for an AXI4 burst.
// Ports: addr (current beat byte address), len (AxLEN), burst (AxBURST),
//        next_addr (address of the following beat).
// FIXED holds, INCR steps by 4, WRAP steps by 4 inside the aligned window of
// (len+1)*4 bytes. The reserved burst type steps like INCR.
module axi4_burst_addr_gen
    import axi4_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        incr_addr = addr + ADDR_W'(4);
        // (len+1)*4-1 is simply len with two ones appended.
        wrap_mask = ADDR_W'({len, 2'b11});
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 slave backed by a word-addressed register-file memory.
// Ports: S_AXI_ACLK (clock), S_AXI_ARESETN (async active-low reset),
//        s_axi (AXI4 bus, slave modport), dbg (engine states).
// Independent write and read engines, one outstanding transaction each.
// Memory contents are not touched by reset.
module axi4_burst_mem_slave
    import axi4_mem_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_ADDR_BITS    = 8
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    axi4_burst_mem_slave_if.slave   s_axi,
    output dbg_t                    dbg
);

    localparam int IDW   = C_S_AXI_ID_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int MI    = C_MEM_ADDR_BITS;
    localparam int DEPTH = 1 << MI;

    logic [DW-1:0] mem [DEPTH];

    // ---------------- write engine ----------------
    wr_state_e      w_state;
    logic [IDW-1:0] w_id;
    logic [AW-1:0]  w_addr;
    logic [AW-1:0]  w_next;
    logic [7:0]     w_len;
    logic [7:0]     w_beat;
    logic [1:0]     w_burst;
    logic           w_err;
    logic           awready_q;
    logic           wready_q;
    logic           bvalid_q;
    logic [1:0]     bresp_q;

    logic aw_hs, w_hs, w_last_beat, wlast_bad, mem_we;

    assign aw_hs       = s_axi.awvalid & awready_q;
    assign w_hs        = s_axi.wvalid & wready_q;
    assign w_last_beat = (w_beat == w_len);
    assign wlast_bad   = (s_axi.wlast != w_last_beat);
    // The beat that exposes a WLAST mismatch is already treated as erroneous.
    assign mem_we      = w_hs & ~w_err & ~wlast_bad;

    axi4_burst_addr_gen #(.ADDR_W(AW)) u_w_addr_gen (
        .addr      (w_addr),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (w_next)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state   <= W_IDLE;
            w_id      <= '0;
            w_addr    <= '0;
            w_len     <= '0;
            w_beat    <= '0;
            w_burst   <= BURST_FIXED;
            w_err     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_id      <= s_axi.awid;
                        w_addr    <= s_axi.awaddr;
                        w_len     <= s_axi.awlen;
                        w_burst   <= s_axi.awburst;
                        w_beat    <= '0;
                        w_err     <= burst_err(s_axi.awsize, s_axi.awburst, s_axi.awlen);
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (wlast_bad) begin
                            w_err <= 1'b1;
                        end
                        // Beat count, not WLAST, ends the data phase.
                        if (w_last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (w_err | wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                            w_state  <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 8'd1;
                            w_addr <= w_next;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            for (int i = 0; i < DW / 8; i++) begin
                if (s_axi.wstrb[i]) begin
                    mem[w_addr[MI+1:2]][8*i +: 8] <= s_axi.wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------- read engine ----------------
    rd_state_e      r_state;
    logic [IDW-1:0] rid_q;
    logic [AW-1:0]  r_addr;
    logic [AW-1:0]  r_next;
    logic [7:0]     r_len;
    logic [7:0]     r_beat;
    logic [1:0]     r_burst;
    logic           r_err;
    logic           arready_q;
    logic           rvalid_q;
    logic           rlast_q;
    logic [1:0]     rresp_q;
    logic [DW-1:0]  rdata_q;

    logic ar_hs, r_hs, ar_err;

    assign ar_hs  = s_axi.arvalid & arready_q;
    assign r_hs   = rvalid_q & s_axi.rready;
    assign ar_err = burst_err(s_axi.arsize, s_axi.arburst, s_axi.arlen);

    axi4_burst_addr_gen #(.ADDR_W(AW)) u_r_addr_gen (
        .addr      (r_addr),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_next)
    );

    // Read data is registered when a beat is presented, so it stays put while
    // the master stalls even if the write engine updates that word meanwhile.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state   <= R_IDLE;
            rid_q     <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_burst   <= BURST_FIXED;
            r_err     <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= s_axi.arid;
                        r_addr    <= s_axi.araddr;
                        r_len     <= s_axi.arlen;
                        r_burst   <= s_axi.arburst;
                        r_beat    <= '0;
                        r_err     <= ar_err;
                        rresp_q   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_q   <= (s_axi.arlen == 8'd0);
                        rdata_q   <= ar_err ? '0 : mem[s_axi.araddr[MI+1:2]];
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= RESP_OKAY;
                            rdata_q   <= '0;
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_beat  <= r_beat + 8'd1;
                            r_addr  <= r_next;
                            rlast_q <= ((r_beat + 8'd1) == r_len);
                            rdata_q <= r_err ? '0 : mem[r_next[MI+1:2]];
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bid     = w_id;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.buser   = 1'b0;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.ruser   = 1'b0;
    assign s_axi.rvalid  = rvalid_q;

    assign dbg.wr_state = w_state;
    assign dbg.rd_state = r_state;

    // Sideband fields are accepted but carry no meaning for this memory.
    logic unused_sideband;
    assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                               s_axi.awregion, s_axi.awuser, s_axi.wuser,
                               s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                               s_axi.arregion, s_axi.aruser};

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Bench for axi4_burst_mem_slave: directed scenarios plus randomized bursts,
// checked against a word-array memory model and per-beat address rules.
module tb_axi4_burst_mem_slave;
    import axi4_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_burst_mem_slave_if #(.ID_W(1), .ADDR_W(32)) bus ();
    dbg_t dbg;

    axi4_burst_mem_slave #(
        .C_S_AXI_ID_WIDTH   (1),
        .C_S_AXI_ADDR_WIDTH (32),
        .C_S_AXI_DATA_WIDTH (32),
        .C_MEM_ADDR_BITS    (8)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus),
        .dbg           (dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [31:0] model_mem [256];
    logic [31:0] wr_buf [256];
    logic [3:0]  wr_strb [256];
    logic [31:0] exp_q [$];
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Error rule: only 4-byte beats, no reserved burst, WRAP only for 2/4/8/16 beats.
    function automatic logic exp_err(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
        int n;
        n = int'(len) + 1;
        if (size != 3'b010) return 1'b1;
        if (burst == 2'b11) return 1'b1;
        if (burst == 2'b10 && !(n == 2 || n == 4 || n == 8 || n == 16)) return 1'b1;
        return 1'b0;
    endfunction

    // Memory word touched by beat i of a burst (256-word memory).
    function automatic int beat_word(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [1:0] burst, input int i);
        int w, n;
        w = int'(addr[9:2]);
        n = int'(len) + 1;
        if (burst == 2'b00) return w;
        if (burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16))
            return (w - (w % n)) + ((w % n) + i) % n;
        return (w + i) % 256;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input int bad_last, input logic id);
        logic err, done;
        int cyc, wd;
        err = exp_err(size, burst, len) || (bad_last >= 0);
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst;
        bus.awsize = size; bus.awid = id;
        cyc = 0;
        while (!bus.awready) begin
            @(negedge clk);
            cyc++;
            if (cyc > 300) begin check({tag, "_aw_timeout"}, 0, 1); bus.awvalid = 1'b0; return; end
        end
        @(negedge clk);
        bus.awvalid = 1'b0;
        check({tag, "_wready_lat"}, bus.wready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            bus.wvalid = 1'b1; bus.wdata = wr_buf[i]; bus.wstrb = wr_strb[i];
            bus.wlast = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
            cyc = 0;
            while (!bus.wready) begin
                @(negedge clk);
                cyc++;
                if (cyc > 300) begin check({tag, "_w_timeout"}, 0, 1); bus.wvalid = 1'b0; return; end
            end
            @(negedge clk);
            if (!exp_err(size, burst, len) && (bad_last < 0 || i < bad_last)) begin
                wd = beat_word(addr, len, burst, i);
                for (int b = 0; b < 4; b++)
                    if (wr_strb[i][b]) model_mem[wd][8*b +: 8] = wr_buf[i][8*b +: 8];
            end
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        check({tag, "_bvalid_lat"}, bus.bvalid, 1);
        done = 1'b0; cyc = 0;
        while (!done) begin
            bus.bready = 1'($urandom_range(0, 1));
            if (!bus.bvalid) begin check({tag, "_bvalid_drop"}, 0, 1); bus.bready = 1'b0; return; end
            check({tag, "_bresp"}, bus.bresp, err ? 2'b10 : 2'b00);
            if (bus.bready) begin
                check({tag, "_bid"}, bus.bid, id);
                done = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (cyc > 300) begin check({tag, "_b_timeout"}, 0, 1); bus.bready = 1'b0; return; end
        end
        bus.bready = 1'b0;
        check({tag, "_bvalid_clr"}, bus.bvalid, 0);
        check({tag, "_awready_back"}, bus.awready, 1);
    endtask

    // stall_mode: 0 = RREADY held high, 1 = toggling, 2 = random.
    task automatic axi_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input int stall_mode, input logic id);
        logic err, tog, stalled;
        logic [31:0] held, exp_data;
        int cyc, beats;
        err = exp_err(size, burst, len);
        exp_q.delete();
        for (int i = 0; i <= int'(len); i++)
            exp_q.push_back(err ? 32'h0 : model_mem[beat_word(addr, len, burst, i)]);
        @(negedge clk);
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
        bus.arsize = size; bus.arid = id;
        cyc = 0;
        while (!bus.arready) begin
            @(negedge clk);
            cyc++;
            if (cyc > 300) begin check({tag, "_ar_timeout"}, 0, 1); bus.arvalid = 1'b0; return; end
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        check({tag, "_rvalid_lat"}, bus.rvalid, 1);
        beats = 0; cyc = 0; tog = 1'b0; stalled = 1'b0; held = '0;
        while (beats <= int'(len)) begin
            case (stall_mode)
                0: bus.rready = 1'b1;
                1: bus.rready = tog;
                default: bus.rready = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            if (!bus.rvalid) begin check({tag, "_rvalid_drop"}, 0, 1); bus.rready = 1'b0; return; end
            if (stalled) check({tag, "_rdata_hold"}, bus.rdata, held);
            if (bus.rready) begin
                exp_data = exp_q.pop_front();
                check({tag, "_rdata"}, bus.rdata, exp_data);
                check({tag, "_rlast"}, bus.rlast, beats == int'(len));
                check({tag, "_rresp"}, bus.rresp, err ? 2'b10 : 2'b00);
                check({tag, "_rid"}, bus.rid, id);
                last_rdata = bus.rdata;
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = bus.rdata;
            end
            @(negedge clk);
            cyc++;
            if (cyc > 2000) begin check({tag, "_r_timeout"}, 0, 1); bus.rready = 1'b0; return; end
        end
        bus.rready = 1'b0;
        check({tag, "_rvalid_clr"}, bus.rvalid, 0);
        check({tag, "_arready_back"}, bus.arready, 1);
    endtask

    task automatic check_outputs_idle(input string tag, input logic exp_ready);
        check({tag, "_awready"}, bus.awready, exp_ready);
        check({tag, "_arready"}, bus.arready, exp_ready);
        check({tag, "_wready"}, bus.wready, 0);
        check({tag, "_bvalid"}, bus.bvalid, 0);
        check({tag, "_bresp"}, bus.bresp, 0);
        check({tag, "_bid"}, bus.bid, 0);
        check({tag, "_buser"}, bus.buser, 0);
        check({tag, "_rvalid"}, bus.rvalid, 0);
        check({tag, "_rdata"}, bus.rdata, 0);
        check({tag, "_rresp"}, bus.rresp, 0);
        check({tag, "_rlast"}, bus.rlast, 0);
        check({tag, "_rid"}, bus.rid, 0);
        check({tag, "_ruser"}, bus.ruser, 0);
    endtask

    task automatic fill_random(input int n, input logic full_strb);
        for (int i = 0; i < n; i++) begin
            wr_buf[i] = $urandom;
            wr_strb[i] = full_strb ? 4'hF : 4'($urandom_range(0, 15));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        logic [1:0]  bt;
        logic [2:0]  sz;
        int cyc;

        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0;
        bus.awuser = '0; bus.awvalid = '0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = '0; bus.wuser = '0; bus.wvalid = '0;
        bus.bready = '0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
        bus.aruser = '0; bus.arvalid = '0;
        bus.rready = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        last_rdata = '0;

        // Reset: outputs low during reset, readies rise one edge after release.
        repeat (3) @(negedge clk);
        check_outputs_idle("in_reset", 1'b0);
        rst_n = 1'b1;
        #1;
        check("pre_edge_awready", bus.awready, 0);
        @(negedge clk);
        check_outputs_idle("post_reset", 1'b1);
        check("dbg_idle", dbg, {W_IDLE, R_IDLE});

        // INCR 16-word write, read back as a 16-beat WRAP from 0.
        for (int i = 0; i < 16; i++) begin
            wr_buf[i] = (i == 15) ? 32'hFFFF_FFFF : 32'h00AB_CDEF + 32'(i) * 32'h0101_0101;
            wr_strb[i] = 4'hF;
        end
        axi_write("incr16_wr", 32'h0, 8'd15, 2'b01, 3'b010, -1, 1'b1);
        axi_read("wrap16_rd", 32'h0, 8'd15, 2'b10, 3'b010, 0, 1'b1);
        check("wrap16_last_word", last_rdata, 32'hFFFF_FFFF);

        // WRAP len=3 from 0x28 -> words 0x28, 0x2C, 0x20, 0x24.
        axi_read("wrap4_rd", 32'h28, 8'd3, 2'b10, 3'b010, 0, 1'b0);
        check("wrap4_last_word", last_rdata, model_mem[9]);

        // 256-beat INCR fill of the whole memory and full read back.
        fill_random(256, 1'b1);
        axi_write("fill_wr", 32'h0, 8'd255, 2'b01, 3'b010, -1, 1'b0);
        axi_read("fill_rd", 32'h0, 8'd255, 2'b01, 3'b010, 2, 1'b0);

        // FIXED byte-lane write over 0xFFFFFFFF.
        wr_buf[0] = 32'hFFFF_FFFF; wr_strb[0] = 4'hF;
        axi_write("fixed_pre", 32'h40, 8'd0, 2'b01, 3'b010, -1, 1'b0);
        wr_buf[0] = 32'h11; wr_buf[1] = 32'h22; wr_buf[2] = 32'h33; wr_buf[3] = 32'h44;
        for (int i = 0; i < 4; i++) wr_strb[i] = 4'b0001;
        axi_write("fixed_wr", 32'h40, 8'd3, 2'b00, 3'b010, -1, 1'b1);
        axi_read("fixed_rd", 32'h40, 8'd0, 2'b01, 3'b010, 0, 1'b1);
        check("fixed_value", last_rdata, 32'hFFFF_FF44);

        // RREADY toggling on an 8-beat read.
        axi_read("toggle_rd", 32'h80, 8'd7, 2'b01, 3'b010, 1, 1'b0);

        // Early WLAST -> SLVERR; then repair the region with a clean write.
        fill_random(4, 1'b1);
        axi_write("badlast_wr", 32'h90, 8'd3, 2'b01, 3'b010, 2, 1'b0);
        fill_random(4, 1'b1);
        axi_write("repair_wr", 32'h90, 8'd3, 2'b01, 3'b010, -1, 1'b0);
        axi_read("repair_rd", 32'h90, 8'd3, 2'b01, 3'b010, 0, 1'b0);

        // Bad AWSIZE -> SLVERR and memory untouched; bad sizes/lens/burst on reads.
        fill_random(4, 1'b1);
        axi_write("size8_wr", 32'h60, 8'd3, 2'b01, 3'b011, -1, 1'b1);
        axi_read("size8_chk_rd", 32'h60, 8'd3, 2'b01, 3'b010, 0, 1'b1);
        axi_read("arsize_err_rd", 32'h60, 8'd1, 2'b01, 3'b001, 0, 1'b0);
        axi_read("wrap_len_err_rd", 32'h60, 8'd2, 2'b10, 3'b010, 0, 1'b0);
        fill_random(3, 1'b1);
        axi_write("rsvd_wr", 32'h70, 8'd2, 2'b11, 3'b010, -1, 1'b0);
        axi_read("rsvd_rd", 32'h70, 8'd2, 2'b11, 3'b010, 0, 1'b1);

        // Reset in the middle of a write burst.
        fill_random(8, 1'b1);
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = 32'h100; bus.awlen = 8'd7; bus.awburst = 2'b01;
        bus.awsize = 3'b010; bus.awid = 1'b1;
        cyc = 0;
        while (!bus.awready && cyc < 300) begin @(negedge clk); cyc++; end
        check("rstmid_aw_seen", bus.awready, 1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wvalid = 1'b1; bus.wdata = wr_buf[i]; bus.wstrb = 4'hF; bus.wlast = 1'b0;
            @(negedge clk);
            if (bus.wready === 1'b1) model_mem[64 + i] = wr_buf[i];
        end
        bus.wvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_bvalid", bus.bvalid, 0);
        check("rstmid_wready", bus.wready, 0);
        check("rstmid_awready", bus.awready, 0);
        repeat (2) @(negedge clk);
        check("rstmid_bvalid_hold", bus.bvalid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_awready_back", bus.awready, 1);
        check("rstmid_no_b", bus.bvalid, 0);
        axi_read("rstmid_rd", 32'h100, 8'd7, 2'b01, 3'b010, 0, 1'b0);
        fill_random(4, 1'b1);
        axi_write("post_rst_wr", 32'h100, 8'd3, 2'b01, 3'b010, -1, 1'b1);
        axi_read("post_rst_rd", 32'h100, 8'd3, 2'b01, 3'b010, 2, 1'b1);

        // Randomized sequential traffic.
        for (int t = 0; t < 40; t++) begin
            bt = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            l = (bt == 2'b10) ? 8'((4 << $urandom_range(0, 2)) - 1) : 8'($urandom_range(0, 31));
            if (bt == 2'b10 && $urandom_range(0, 3) == 0) l = 8'd1;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            a = $urandom;
            fill_random(int'(l) + 1, 1'b0);
            axi_write("rnd_wr", a, l, bt, sz, -1, 1'($urandom_range(0, 1)));
            axi_read("rnd_rd", a, l, bt, 3'b010, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Concurrent write (low half) and read (high half).
        for (int t = 0; t < 10; t++) begin
            logic [31:0] wa, ra;
            logic [7:0]  wl, rl;
            logic [1:0]  wb, rb;
            wb = 2'($urandom_range(0, 2));
            wl = (wb == 2'b10) ? 8'd7 : 8'($urandom_range(0, 15));
            wa = {22'd0, 8'($urandom_range(0, 112)), 2'b00};
            rb = 2'($urandom_range(0, 2));
            rl = (rb == 2'b10) ? 8'd15 : 8'($urandom_range(0, 15));
            ra = {22'd0, 8'($urandom_range(128, 240)), 2'b00};
            fill_random(int'(wl) + 1, 1'b0);
            fork
                axi_write("conc_wr", wa, wl, wb, 3'b010, -1, 1'b0);
                axi_read("conc_rd", ra, rl, rb, 3'b010, 2, 1'b1);
            join
        end
        axi_read("conc_final_rd", 32'h0, 8'd255, 2'b01, 3'b010, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
